// File: rtl/shared_pkg.sv
// Shared types and constants for the SPI-RAM subsystem.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package shared_pkg;

    // RAM data/address width; one SPI frame carries two control bits on top.
    localparam int MEM_WIDTH = 8;
    localparam int FRAME_LEN = MEM_WIDTH + 2;

    // Frame control code carried in the two MSBs of every frame.
    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } control_e;

    // SPI slave front-end states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_e;

    // True when a frame's control code is legal for the state that received it.
    // WRITE is entered on a 0 MSB, so either write code is acceptable there.
    function automatic logic ctrl_matches(input spi_state_e st, input logic [1:0] ctrl);
        logic ok;
        ok = 1'b0;
        case (st)
            WRITE:     ok = (ctrl == WR_ADDR) || (ctrl == WR_DATA);
            READ_ADD:  ok = (ctrl == RD_ADDR);
            READ_DATA: ok = (ctrl == RD_DATA);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/spi_miso_serializer.sv
// MISO serializer: loads a RAM read byte and shifts it out MSB first.
// Latency: first bit on o_miso the clk after i_load; W bits, then 0; o_done pulses after the last bit.
// Backpressure: none; i_load is ignored while a byte is shifting, i_clr aborts and forces o_miso low.
module spi_miso_serializer #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_dat,
    output logic         o_miso,
    output logic         o_done
);

    logic [W-1:0]  r_sh;
    logic [CW-1:0] r_rem;
    logic          r_busy;
    logic          r_miso;
    logic          r_done;

    // Load, shift and terminate the MISO byte; SS_n high (i_clr) wipes everything.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh   <= '0;
            r_rem  <= '0;
            r_busy <= 1'b0;
            r_miso <= 1'b0;
            r_done <= 1'b0;
        end else if (i_clr) begin
            r_sh   <= '0;
            r_rem  <= '0;
            r_busy <= 1'b0;
            r_miso <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_load && !r_busy) begin
                // MSB goes straight to the pin; the rest waits in the shifter.
                r_miso <= i_dat[W-1];
                r_sh   <= {i_dat[W-2:0], 1'b0};
                r_rem  <= CW'(W - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (r_rem != '0) begin
                    r_miso <= r_sh[W-1];
                    r_sh   <= {r_sh[W-2:0], 1'b0};
                    r_rem  <= r_rem - 1'b1;
                end else begin
                    r_miso <= 1'b0;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_miso = r_miso;
    assign o_done = r_done;

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front end: deserialises MOSI frames into {ctrl, payload} words and returns RAM read bytes on MISO.
// Latency: rx_valid rises MEM_WIDTH+3 clks after the first SS_n-low sample; MISO starts the clk after tx_valid.
// Backpressure: none; SS_n high aborts a frame. Define SPI_SLAVE_CMD_CHECK_EN to drop mis-coded frames and add frame_err.
module spi_slave_fsm #(
    parameter int MEM_WIDTH = shared_pkg::MEM_WIDTH,
    parameter int CNT_W     = $clog2(MEM_WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [MEM_WIDTH+1:0] rx_data,
    output logic                 rx_valid,
`ifdef SPI_SLAVE_CMD_CHECK_EN
    output logic                 frame_err,
`endif
    input  logic [MEM_WIDTH-1:0] tx_data,
    input  logic                 tx_valid
);

    import shared_pkg::*;

    localparam int FLEN = MEM_WIDTH + 2;

    spi_state_e          r_state;
    spi_state_e          w_next;

    logic [CNT_W-1:0]    r_cnt;      // frame bits captured so far
    logic [FLEN-1:0]     r_shift;    // frame being assembled, MSB first
    logic                r_done;     // frame finished; ignore MOSI until SS_n rises
    logic                r_rd_seen;  // a read-address frame is awaiting its read-data frame
    logic                r_rd_done;  // MISO byte already returned for this frame
    logic [FLEN-1:0]     r_rx_data;
    logic                r_rx_valid;

    logic                w_start;    // capture the command MSB
    logic                w_shift;    // capture one payload bit
    logic                w_complete; // all FLEN bits are in
    logic                w_ctrl_ok;
    logic                w_forward;
    logic                w_load;
    logic                w_ser_done;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_shift    = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            IDLE: begin
                if (!SS_n) begin
                    w_next = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    w_next = IDLE;
                end else begin
                    w_start = 1'b1;
                    if (!MOSI) begin
                        w_next = WRITE;
                    end else if (r_rd_seen) begin
                        w_next = READ_DATA;
                    end else begin
                        w_next = READ_ADD;
                    end
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    w_next = IDLE;
                end else if (!r_done) begin
                    if (r_cnt != CNT_W'(FLEN)) begin
                        w_shift = 1'b1;
                    end else begin
                        w_complete = 1'b1;
                    end
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef SPI_SLAVE_CMD_CHECK_EN
    assign w_ctrl_ok = ctrl_matches(r_state, r_shift[FLEN-1:FLEN-2]);
`else
    assign w_ctrl_ok = 1'b1;
`endif

    assign w_forward = w_complete && w_ctrl_ok;

    // Frame assembly, rx strobe and read-address tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_done     <= 1'b0;
            r_rd_seen  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (SS_n || (r_state == IDLE)) begin
                r_cnt  <= '0;
                r_done <= 1'b0;
            end
            if (w_start) begin
                r_shift <= {{(FLEN-1){1'b0}}, MOSI};
                r_cnt   <= CNT_W'(1);
            end
            if (w_shift) begin
                r_shift <= {r_shift[FLEN-2:0], MOSI};
                r_cnt   <= r_cnt + 1'b1;
            end
            if (w_complete) begin
                r_done <= 1'b1;
            end
            if (w_forward) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
                if (r_state == READ_ADD) begin
                    r_rd_seen <= 1'b1;
                end else if (r_state == READ_DATA) begin
                    r_rd_seen <= 1'b0;
                end
            end
        end
    end

`ifdef SPI_SLAVE_CMD_CHECK_EN
    logic r_frame_err;

    // One-cycle error pulse for a completed frame whose code disagrees with its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_complete && !w_ctrl_ok;
        end
    end

    assign frame_err = r_frame_err;
`endif

    // One read byte per READ_DATA frame; cleared when the master deselects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_done <= 1'b0;
        end else if (SS_n) begin
            r_rd_done <= 1'b0;
        end else if (w_ser_done) begin
            r_rd_done <= 1'b1;
        end
    end

    // tx_valid only counts once the READ_DATA frame itself has completed.
    assign w_load = tx_valid && (r_state == READ_DATA) && r_done && !SS_n && !r_rd_done;

    spi_miso_serializer #(
        .W (MEM_WIDTH)
    ) u_miso_ser (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (SS_n),
        .i_load (w_load),
        .i_dat  (tx_data),
        .o_miso (MISO),
        .o_done (w_ser_done)
    );

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Scoreboard bench for spi_slave_fsm: stimulus pushes expected rx words and MISO bits, a monitor checks them.
// Latency: expected rx_valid 11 clks after the first SS_n-low sample; MISO bits from the clk after tx_valid.
// Backpressure: none; all waits are fixed cycle counts under a global watchdog.
module tb_spi_slave_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
`ifdef SPI_SLAVE_CMD_CHECK_EN
    logic       frame_err;
`endif

    spi_slave_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
`ifdef SPI_SLAVE_CMD_CHECK_EN
        .frame_err(frame_err),
`endif
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0] dat;
        int         cyc;
    } rx_exp_t;

    typedef struct {
        logic b;
        int   cyc;
    } miso_exp_t;

    rx_exp_t   rxq[$];
    miso_exp_t mq[$];
    rx_exp_t   e_mon;
    miso_exp_t m_mon;

    int checks    = 0;
    int failures  = 0;
    int n_rxv     = 0;
    int n_exp_rx  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_miso(input int c, input logic b);
        miso_exp_t m;
        m.cyc = c;
        m.b   = b;
        mq.push_back(m);
    endtask

    // Monitor: pops expectations when the DUT strobes rx_valid or a MISO bit is due.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                n_rxv++;
                if (rxq.size() == 0) begin
                    check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
                end else begin
                    e_mon = rxq.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e_mon.dat));
                    check("rx_latency", 32'(cyc), 32'(e_mon.cyc));
                end
            end
            while (mq.size() > 0 && mq[0].cyc <= cyc) begin
                m_mon = mq.pop_front();
                if (m_mon.cyc != cyc)
                    check("miso_missed", 32'(cyc), 32'(m_mon.cyc));
                else
                    check("miso", 32'(MISO), 32'(m_mon.b));
            end
        end
    end

    // Full frame: leaves SS_n low and returns at the negedge where rx_valid is due.
    task automatic send_frame(input logic [9:0] f, input bit exp_valid, output int c);
        rx_exp_t e;
        @(negedge clk);
        SS_n = 1'b0;
        c    = cyc;
        if (exp_valid) begin
            e.dat = f;
            e.cyc = c + 12;
            rxq.push_back(e);
            n_exp_rx++;
        end
        for (int i = 1; i <= 12; i++) push_miso(c + i, 1'b0);
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            MOSI = f[i];
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        push_miso(cyc + 1, 1'b0);
        @(negedge clk);
    endtask

    // One-clk tx_valid pulse; expects the byte on MISO or, when ignored, a quiet line.
    task automatic send_tx(input logic [7:0] d, input bit expect_out);
        int d0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        d0       = cyc;
        for (int i = 0; i < 8; i++) push_miso(d0 + 1 + i, expect_out ? d[7-i] : 1'b0);
        push_miso(d0 + 9, 1'b0);
        push_miso(d0 + 10, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
    endtask

    task automatic abort_frame(input logic [9:0] f, input int nbits);
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 1; i <= nbits + 2; i++) push_miso(cyc + i, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            MOSI = f[9-i];
        end
        @(negedge clk);
        SS_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int c;
        int d0;
        rst      = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #1;
        check("reset_miso", 32'(MISO), 32'h0);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Write address, then write data with a stray tx_valid that must be ignored.
        send_frame(10'h03C, 1'b1, c);
        end_frame();
        send_frame(10'h1A5, 1'b1, c);
        send_tx(8'hA5, 1'b0);
        end_frame();

        // Read address (tx_valid ignored there), then read data returning 0xA5.
        send_frame(10'h23C, 1'b1, c);
        send_tx(8'h5A, 1'b0);
        end_frame();
        send_frame(10'h300, 1'b1, c);
        send_tx(8'hA5, 1'b1);
        end_frame();

        // Abort after 5 bits; a frame starting the very next clk must decode.
        abort_frame(10'h155, 5);
        check("rx_data_hold", 32'(rx_data), 32'h300);
        send_frame(10'h155, 1'b1, c);
        end_frame();

        // Reset in the middle of a MISO byte (0x6B), after three bits.
        send_frame(10'h2AA, 1'b1, c);
        end_frame();
        send_frame(10'h3C3, 1'b1, c);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h6B;
        d0       = cyc;
        push_miso(d0 + 1, 1'b0);
        push_miso(d0 + 2, 1'b1);
        push_miso(d0 + 3, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst  = 1'b1;
        SS_n = 1'b1;
        #1;
        check("midreset_miso", 32'(MISO), 32'h0);
        check("midreset_rx_valid", 32'(rx_valid), 32'h0);
        check("midreset_rx_data", 32'(rx_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // After reset the next read frame is a read address: tx_valid must be ignored.
        send_frame(10'h2F0, 1'b1, c);
        send_tx(8'hFF, 1'b0);
        end_frame();
        send_frame(10'h30F, 1'b1, c);
        send_tx(8'hC3, 1'b1);
        end_frame();

`ifdef SPI_SLAVE_CMD_CHECK_EN
        // With a read address pending, a 1_0 frame lands in READ_DATA and is dropped.
        send_frame(10'h211, 1'b1, c);
        end_frame();
        send_frame(10'h255, 1'b0, c);
        check("frame_err_pulse", 32'(frame_err), 32'h1);
        check("rx_data_after_err", 32'(rx_data), 32'h211);
        @(negedge clk);
        check("frame_err_one_clk", 32'(frame_err), 32'h0);
        end_frame();
        send_frame(10'h3AA, 1'b1, c);
        check("frame_err_good", 32'(frame_err), 32'h0);
        send_tx(8'h81, 1'b1);
        end_frame();
`endif

        repeat (4) @(negedge clk);
        check("rx_count", 32'(n_rxv), 32'(n_exp_rx));
        check("rx_queue_left", 32'(rxq.size()), 32'h0);
        check("miso_queue_left", 32'(mq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
